// File: rtl/prog_loader.sv
// Streams a program into instruction memory, holds the CPU in reset, then runs it for a bounded or unbounded time.
// Latency: a memory write strobe appears one cycle after each accepted word; cpu_rst releases HOLD_CYC cycles after the last word.
// Backpressure: in_ready is high only while loading; the stream is never stalled mid-load, and overflow parks the block in ERR.
module prog_loader #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [15:0]       run_limit,
    input  logic              halt,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Last HOLD cycle index; the hold counter starts at zero on entry.
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_err;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W:0]   r_word_count;
    logic [15:0]       r_hold_cnt;
    logic [15:0]       r_run_cnt;
    logic [15:0]       r_run_limit;

    logic              w_at_top;
    logic              w_hold_end;
    logic              w_run_end;

    // Word about to be written lands in the last memory slot.
    assign w_at_top   = (r_word_count[ADDR_W-1:0] == {ADDR_W{1'b1}});
    // This HOLD cycle is the final one of the reset pulse.
    assign w_hold_end = (r_hold_cnt == HOLD_LAST);
    // This RUN cycle is the N-th one for a non-zero limit; zero means run until halted.
    assign w_run_end  = (r_run_limit != 16'd0) && (r_run_cnt == (r_run_limit - 16'd1));

    // Sequencer: state, registered status outputs and the memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_word_count <= '0;
            r_hold_cnt   <= '0;
            r_run_cnt    <= '0;
            r_run_limit  <= '0;
        end else begin
            // Strobe is a single-cycle pulse; address and data keep their last value.
            r_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_start) begin
                        r_state      <= S_LOAD;
                        r_in_ready   <= 1'b1;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_word_count <= '0;
                        r_run_limit  <= run_limit;
                    end
                end
                S_LOAD: begin
                    // in_ready is high throughout LOAD, so in_valid alone marks a transfer.
                    if (in_valid) begin
                        r_we         <= 1'b1;
                        r_addr       <= r_word_count[ADDR_W-1:0];
                        r_wdata      <= in_data;
                        r_word_count <= r_word_count + (ADDR_W+1)'(1);
                        if (in_last) begin
                            // A last word in the top slot is still a clean finish.
                            r_state    <= S_HOLD;
                            r_in_ready <= 1'b0;
                            r_hold_cnt <= '0;
                        end else if (w_at_top) begin
                            // Memory is full and the program has not ended.
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_err      <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_hold_end) begin
                        r_state   <= S_RUN;
                        r_cpu_rst <= 1'b0;
                        r_run_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 16'd1;
                    end
                end
                S_RUN: begin
                    r_run_cnt <= r_run_cnt + 16'd1;
                    // Halt and limit expiry lead to the same place; halt needs no limit.
                    if (halt || w_run_end) begin
                        r_state   <= S_DONE;
                        r_cpu_rst <= 1'b1;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_cpu_rst  <= 1'b1;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign word_count = r_word_count;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed loads with a cycle-level reference model and literal spot checks.
// Inputs change on the falling edge; the model and monitor sample on the rising edge plus 1.
// Every wait on the design is bounded; an expired bound shows up as a failed check.
module tb_prog_loader;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 8;
    localparam int HOLD_CYC = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic [15:0]       run_limit = 16'd0;
    logic              halt = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_rst;
    logic [ADDR_W:0]   word_count;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HOLD_CYC(HOLD_CYC)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .run_limit(run_limit), .halt(halt),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .word_count(word_count), .done(done), .err(err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: phase plus countdown/count-up bookkeeping.
    typedef enum {M_IDLE, M_LOAD, M_HOLD, M_RUN, M_DONE, M_ERR} mphase_t;
    mphase_t m_phase = M_IDLE;
    bit m_live = 0;
    bit m_we = 0;
    int m_wc = 0, m_addr = 0, m_wdata = 0, m_hold_left = 0, m_ran = 0, m_limit = 0;

    // Observed write log, cleared by each test.
    int wr_addr_q[$];
    int wr_data_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_live = 1; m_phase = M_IDLE; m_we = 0; m_wc = 0; m_addr = 0; m_wdata = 0;
        end else if (m_live) begin
            m_we = 0;
            case (m_phase)
                M_IDLE, M_DONE, M_ERR: if (load_start) begin
                    m_phase = M_LOAD; m_wc = 0; m_limit = int'(run_limit);
                end
                M_LOAD: if (in_valid) begin
                    m_we = 1; m_addr = m_wc; m_wdata = int'(in_data); m_wc++;
                    if (in_last) begin m_phase = M_HOLD; m_hold_left = HOLD_CYC; end
                    else if (m_wc == 2**ADDR_W) m_phase = M_ERR;
                end
                M_HOLD: begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin m_phase = M_RUN; m_ran = 0; end
                end
                M_RUN: begin
                    m_ran++;
                    if (halt || (m_limit != 0 && m_ran == m_limit)) m_phase = M_DONE;
                end
                default: ;
            endcase
        end
        #1;
        if (m_live) begin
            check("cyc_in_ready", 32'(in_ready), 32'(m_phase == M_LOAD));
            check("cyc_cpu_rst", 32'(cpu_rst), 32'(m_phase != M_RUN));
            check("cyc_done", 32'(done), 32'(m_phase == M_DONE));
            check("cyc_err", 32'(err), 32'(m_phase == M_ERR));
            check("cyc_word_count", 32'(word_count), m_wc);
            check("cyc_imem_we", 32'(imem_we), 32'(m_we));
            check("cyc_imem_addr", 32'(imem_addr), m_addr);
            check("cyc_imem_wdata", 32'(imem_wdata), m_wdata);
            if (imem_we) begin
                wr_addr_q.push_back(int'(imem_addr));
                wr_data_q.push_back(int'(imem_wdata));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_load(input logic [15:0] lim);
        load_start = 1'b1; run_limit = lim;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        in_valid = 1'b1; in_data = d; in_last = last;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Cycles cpu_rst stays high from now on (bounded).
    task automatic wait_rst_low(output int n);
        n = 0;
        while (cpu_rst === 1'b1 && n < 100) begin n++; tick(); end
        check("timeout_hold", 32'(cpu_rst), 0);
    endtask

    // Cycles cpu_rst stays low from now on (bounded).
    task automatic count_run(output int n);
        n = 0;
        while (cpu_rst === 1'b0 && n < 1000) begin n++; tick(); end
        check("timeout_run", 32'(cpu_rst), 1);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        int h, r;
        logic [15:0] exp_d [4];
        tick(); tick();
        // Reset state
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_cpu_rst", 32'(cpu_rst), 1);
        check("rst_word_count", 32'(word_count), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_imem_wdata", 32'(imem_wdata), 0);
        rst = 1'b0;
        tick();

        // Three-word program, run limit 10
        clear_log();
        start_load(16'd10);
        check("t1_in_ready", 32'(in_ready), 1);
        send(16'h1234, 1'b0);
        send(16'h5678, 1'b0);
        send(16'h9ABC, 1'b1);
        wait_rst_low(h);
        check("t1_hold_cycles", h, 4);
        count_run(r);
        check("t1_run_cycles", r, 10);
        check("t1_done", 32'(done), 1);
        check("t1_word_count", 32'(word_count), 3);
        check("t1_nwrites", wr_addr_q.size(), 3);
        if (wr_addr_q.size() == 3) begin
            check("t1_addr0", wr_addr_q[0], 0); check("t1_data0", wr_data_q[0], 'h1234);
            check("t1_addr1", wr_addr_q[1], 1); check("t1_data1", wr_data_q[1], 'h5678);
            check("t1_addr2", wr_addr_q[2], 2); check("t1_data2", wr_data_q[2], 'h9ABC);
        end

        // Valid toggling 1,0,1,0: contiguous addresses, writes only on valid cycles
        clear_log();
        start_load(16'd2);
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 16'hA000 + 16'(i);
            in_last  = (i == 6);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        wait_rst_low(h);
        count_run(r);
        check("t2_run_cycles", r, 2);
        check("t2_word_count", 32'(word_count), 4);
        check("t2_nwrites", wr_addr_q.size(), 4);
        exp_d[0] = 16'hA000; exp_d[1] = 16'hA002; exp_d[2] = 16'hA004; exp_d[3] = 16'hA006;
        if (wr_addr_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t2_addr", wr_addr_q[i], i);
                check("t2_data", wr_data_q[i], 32'(exp_d[i]));
            end
        end

        // One-word program; load_start during RUN is ignored
        clear_log();
        start_load(16'd20);
        send(16'hBEEF, 1'b1);
        wait_rst_low(h);
        for (int i = 0; i < 5; i++) tick();
        load_start = 1'b1; run_limit = 16'd3;
        tick();
        load_start = 1'b0;
        count_run(r);
        check("t3_run_cycles", r + 6, 20);
        check("t3_done", 32'(done), 1);
        check("t3_word_count", 32'(word_count), 1);
        check("t3_nwrites", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) check("t3_data0", wr_data_q[0], 'hBEEF);

        // Unlimited run ended by halt after 50 RUN cycles; halt during LOAD ignored
        clear_log();
        start_load(16'd0);
        halt = 1'b1;
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b1);
        halt = 1'b0;
        wait_rst_low(h);
        check("t4_hold_cycles", h, 4);
        for (int i = 0; i < 49; i++) tick();
        check("t4_still_run", 32'(cpu_rst), 0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("t4_done", 32'(done), 1);
        check("t4_cpu_rst", 32'(cpu_rst), 1);
        check("t4_nwrites", wr_addr_q.size(), 2);

        // 256 words without last: overflow into ERR, then a clean reload
        clear_log();
        start_load(16'd5);
        in_valid = 1'b1; in_last = 1'b0;
        for (int i = 0; i < 256; i++) begin
            in_data = 16'((i * 257) ^ 'h5A5A);
            tick();
        end
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        check("t5_err", 32'(err), 1);
        check("t5_in_ready", 32'(in_ready), 0);
        check("t5_cpu_rst", 32'(cpu_rst), 1);
        check("t5_done", 32'(done), 0);
        check("t5_word_count", 32'(word_count), 256);
        check("t5_nwrites", wr_addr_q.size(), 256);
        if (wr_addr_q.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                check("t5_addr", wr_addr_q[i], i);
                check("t5_data", wr_data_q[i], 32'(16'((i * 257) ^ 'h5A5A)));
            end
        end
        for (int i = 0; i < 5; i++) tick();
        check("t5_cpu_rst_held", 32'(cpu_rst), 1);
        clear_log();
        start_load(16'd3);
        check("t5r_err", 32'(err), 0);
        check("t5r_in_ready", 32'(in_ready), 1);
        check("t5r_word_count", 32'(word_count), 0);
        send(16'hCAFE, 1'b1);
        wait_rst_low(h);
        count_run(r);
        check("t5r_run_cycles", r, 3);
        check("t5r_done", 32'(done), 1);
        check("t5r_nwrites", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) begin
            check("t5r_addr0", wr_addr_q[0], 0);
            check("t5r_data0", wr_data_q[0], 'hCAFE);
        end

        // Reset after the second word beats a pending transfer, load_start and halt
        clear_log();
        start_load(16'd7);
        send(16'h0101, 1'b0);
        send(16'h0202, 1'b0);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h0303; load_start = 1'b1; halt = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; load_start = 1'b0; halt = 1'b0;
        check("t6_imem_we", 32'(imem_we), 0);
        check("t6_word_count", 32'(word_count), 0);
        check("t6_cpu_rst", 32'(cpu_rst), 1);
        check("t6_in_ready", 32'(in_ready), 0);
        check("t6_imem_addr", 32'(imem_addr), 0);
        check("t6_nwrites", wr_addr_q.size(), 2);
        tick(); tick();
        check("t6_idle_ready", 32'(in_ready), 0);
        check("t6_idle_done", 32'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, instruction word width.
REQ-002 SHALL provide parameter ADDR_W, default 8, instruction memory address width (depth 2**ADDR_W).
REQ-003 SHALL provide parameter HOLD_CYC, default 4, cycles cpu_rst stays high after load completes.
REQ-004 SHALL have one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 load_start  input  1  one-cycle request to begin a program load.
REQ-007 run_limit  input  16  CPU run length in cycles, sampled on accepted load_start; 0 = unlimited.
REQ-008 halt  input  1  abort CPU run.
REQ-009 in_valid  input  1  stream word valid.
REQ-010 in_data  input  DATA_W  stream instruction word.
REQ-011 in_last  input  1  marks final word of program.
REQ-012 in_ready  output  1  loader accepts stream word.
REQ-013 imem_we  output  1  instruction memory write strobe.
REQ-014 imem_addr  output  ADDR_W  instruction memory write address.
REQ-015 imem_wdata  output  DATA_W  instruction memory write data.
REQ-016 cpu_rst  output  1  reset to CPU core, active-high.
REQ-017 word_count  output  ADDR_W+1  words written in current load.
REQ-018 done  output  1  run finished, level.
REQ-019 err  output  1  overflow error, level.

Function
REQ-020 SHALL implement states IDLE, LOAD, HOLD, RUN, DONE, ERR.
REQ-021 IDLE/DONE/ERR: load_start=1 -> LOAD next edge; word_count cleared, run_limit latched, done/err cleared.
REQ-022 load_start SHALL be ignored in LOAD, HOLD, RUN.
REQ-023 in_ready SHALL equal 1 exactly when state is LOAD; transfer occurs when in_valid and in_ready high at a rising edge.
REQ-024 On transfer: cycle after, imem_we=1 for one cycle, imem_addr=word_count prior to transfer, imem_wdata=in_data; word_count increments at same edge.
REQ-025 imem_we SHALL be 0 in all cycles not following a transfer; imem_addr/imem_wdata hold last values.
REQ-026 Transfer with in_last=1 -> HOLD (including transfer at address 2**ADDR_W-1).
REQ-027 Transfer at address 2**ADDR_W-1 with in_last=0 -> word written, then ERR; err=1, in_ready=0, no further writes.
REQ-028 Transfer with in_last=1 and zero prior words is legal (1-word program).
REQ-029 HOLD: cpu_rst=1 for exactly HOLD_CYC cycles, then RUN.
REQ-030 RUN: cpu_rst=0; 16-bit cycle counter from 0 increments each RUN cycle.
REQ-031 RUN with run_limit=N>0: after exactly N cycles with cpu_rst=0 -> DONE.
REQ-032 RUN with run_limit=0: remain in RUN until halt.
REQ-033 halt=1 in RUN -> DONE next edge, wins over limit same cycle; halt ignored in other states.
REQ-034 cpu_rst SHALL be 1 in every state except RUN.
REQ-035 done=1 exactly in DONE; err=1 exactly in ERR.
REQ-036 word_count SHALL hold its final value through HOLD, RUN, DONE, ERR.

Reset
REQ-037 rst=1 at an edge from any state -> IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, word_count=0, done=0, err=0, cycle counter=0.
REQ-038 rst mid-LOAD SHALL abort with no write strobe in the following cycle.
REQ-039 rst SHALL take priority over load_start, halt and stream transfers in the same cycle.

Verification
REQ-040 Load 3 words 0x1234,0x5678,0x9ABC (last on third), run_limit=10 -> writes addr 0,1,2 with those data; cpu_rst high 4 cycles, low 10 cycles; done=1; word_count=3.
REQ-041 Backpressure-free stream with in_valid toggling 1,0,1,0 -> writes only on valid cycles, addresses contiguous, no gaps in address.
REQ-042 256 words, none last -> 256 writes to addr 0..255, err=1, in_ready=0, cpu_rst stays 1; load_start then reloads cleanly.
REQ-043 run_limit=0, halt pulsed after 50 RUN cycles -> DONE next edge, cpu_rst=1, done=1.
REQ-044 rst asserted after second word of a load -> IDLE, cpu_rst=1, word_count=0, imem_we=0 next cycle.
REQ-045 load_start pulsed during RUN -> ignored, run completes at run_limit.
